// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding request/response front end for a registered-read RAM.
// Define MEM_CTRL_OOB_CHECK_EN to flag addresses >= DATA_DEPTH instead of accessing RAM.
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_DEPTH  = 65536,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

`ifdef MEM_CTRL_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  oob_q, oob_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  req_oob;

  // Folds to 0 when checking is disabled, so every address reaches the RAM.
  assign req_oob = OOB_EN && (64'(req_addr) >= 64'(DATA_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      oob_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      oob_q         <= oob_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    oob_d         = oob_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          wdata_d     = req_wdata;
          oob_d       = req_oob;
          req_ready_d = 1'b0;
          if (req_oob) begin
            // Bypass the RAM: a zero-length WAIT turns into RESP on the next edge.
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            mem_addr_d    = req_addr;
            mem_wr_data_d = req_wdata;
            mem_wr_en_d   = req_we;
            state_d       = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_wr_en_d = 1'b0;
        cnt_d       = CNT_W'(WAIT_STATES);
        state_d     = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = oob_q;
          if (oob_q)     rsp_rdata_d = '0;
          else if (we_q) rsp_rdata_d = wdata_q;
          else           rsp_rdata_d = mem_rd_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: two instances (WAIT_STATES=0 with DATA_DEPTH=256, WAIT_STATES=3),
// each with a registered-read RAM model; expected responses tracked in a scoreboard queue.
module tb_mem_ctrl;

`ifdef MEM_CTRL_OOB_CHECK_EN
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_we      [2];
  logic [15:0] req_addr    [2];
  logic [15:0] req_wdata   [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [15:0] rsp_rdata   [2];
  logic        rsp_err     [2];
  logic        mem_wr_en   [2];
  logic [15:0] mem_addr    [2];
  logic [15:0] mem_wr_data [2];
  logic [15:0] mem_rd_data [2];

  logic [15:0] ram0 [65536];
  logic [15:0] ram1 [65536];
  logic        preload = 1'b0;
  int          wr_cnt0 = 0;
  int          wr_cnt1 = 0;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DATA_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_wr_en(mem_wr_en[0]), .mem_addr(mem_addr[0]),
    .mem_wr_data(mem_wr_data[0]), .mem_rd_data(mem_rd_data[0])
  );

  mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DATA_DEPTH(65536), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_wr_en(mem_wr_en[1]), .mem_addr(mem_addr[1]),
    .mem_wr_data(mem_wr_data[1]), .mem_rd_data(mem_rd_data[1])
  );

  // Registered-read RAMs; a write counter per port tracks mem_wr_en cycles.
  always @(posedge clk) begin
    if (mem_wr_en[0]) begin
      ram0[mem_addr[0]] <= mem_wr_data[0];
      wr_cnt0 <= wr_cnt0 + 1;
    end
    mem_rd_data[0] <= ram0[mem_addr[0]];
    if (preload)
      ram1[16'h0005] <= 16'hBEEF;
    else if (mem_wr_en[1])
      ram1[mem_addr[1]] <= mem_wr_data[1];
    if (mem_wr_en[1])
      wr_cnt1 <= wr_cnt1 + 1;
    mem_rd_data[1] <= ram1[mem_addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wr_count(input int d);
    return (d == 0) ? wr_cnt0 : wr_cnt1;
  endfunction

  // One complete transaction on DUT d; bp > 0 holds rsp_ready low for bp cycles in RESP.
  task automatic txn(input int d, input logic we, input logic [15:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_wr, input int bp);
    exp_t e;
    int   wc;
    int   lat;
    int   n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    wc = wr_count(d);
    rsp_ready[d] = (bp == 0);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_wait d%0d a%0h", d, addr), n, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    chk($sformatf("busy_ready d%0d", d), {31'd0, req_ready[d]}, 0);
    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency d%0d a%0h", d, addr), lat, exp_lat);
    for (int i = 0; i < bp; i++) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = addr ^ 16'h0040;
      req_wdata[d] = 16'hDEAD;
      @(negedge clk);
      chk($sformatf("bp_valid d%0d c%0d", d, i), {31'd0, rsp_valid[d]}, 1);
      chk($sformatf("bp_rdata d%0d c%0d", d, i), {16'd0, rsp_rdata[d]}, {16'd0, sb[0].rdata});
      chk($sformatf("bp_ready d%0d c%0d", d, i), {31'd0, req_ready[d]}, 0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    e = sb.pop_front();
    chk($sformatf("rdata d%0d a%0h", d, addr), {16'd0, rsp_rdata[d]}, {16'd0, e.rdata});
    chk($sformatf("err d%0d a%0h", d, addr), {31'd0, rsp_err[d]}, {31'd0, e.err});
    @(negedge clk);
    chk($sformatf("rsp_drop d%0d", d), {31'd0, rsp_valid[d]}, 0);
    chk($sformatf("idle_ready d%0d", d), {31'd0, req_ready[d]}, 1);
    chk($sformatf("wr_pulses d%0d a%0h", d, addr), wr_count(d) - wc, exp_wr);
    $display("txn d%0d we=%0d addr=%04h wdata=%04h -> rdata=%04h err=%0d lat=%0d",
             d, we, addr, wd, e.rdata, e.err, lat);
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b1;
    end
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    chk("rst_req_ready", {31'd0, req_ready[0]}, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata[0]}, 0);
    chk("rst_rsp_err", {31'd0, rsp_err[0]}, 0);
    chk("rst_mem_wr_en", {31'd0, mem_wr_en[0]}, 0);
    chk("rst_mem_addr", {16'd0, mem_addr[0]}, 0);
    chk("rst_mem_wr_data", {16'd0, mem_wr_data[0]}, 0);
    chk("rst_rsp_valid1", {31'd0, rsp_valid[1]}, 0);
    rst = 1'b0;

    // First accept on the first edge after reset release.
    txn(0, 1'b1, 16'h0010, 16'h1234, 16'h1234, 1'b0, 2, 1, 0);
    txn(0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 2, 0, 0);
    txn(1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 5, 0, 0);
    txn(1, 1'b1, 16'h0033, 16'hC0DE, 16'hC0DE, 1'b0, 5, 1, 10);
    txn(1, 1'b0, 16'h0033, 16'h0000, 16'hC0DE, 1'b0, 5, 0, 0);
    txn(1, 1'b0, 16'h0073, 16'h0000, ram1[16'h0073], 1'b0, 5, 0, 0);
    txn(1, 1'b1, 16'hFFFF, 16'h55AA, 16'h55AA, 1'b0, 5, 1, 0);
    txn(1, 1'b0, 16'hFFFF, 16'h0000, 16'h55AA, 1'b0, 5, 0, 0);

    // Reset while a write is in ACCESS.
    txn(0, 1'b1, 16'h0020, 16'h5A5A, 16'h5A5A, 1'b0, 2, 1, 0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h0020;
    req_wdata[0] = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("access_wr_en", {31'd0, mem_wr_en[0]}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_wr_en", {31'd0, mem_wr_en[0]}, 0);
    chk("rst_async_ready", {31'd0, req_ready[0]}, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    chk("aborted_no_rsp", seen, 0);
    txn(0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 1'b0, 2, 0, 0);

    // Address at DATA_DEPTH of the first instance.
    txn(0, 1'b1, 16'h0100, 16'h7777, OOB ? 16'h0000 : 16'h7777, OOB, OOB ? 1 : 2, OOB ? 0 : 1, 0);
    txn(0, 1'b0, 16'h0100, 16'h0000, OOB ? 16'h0000 : 16'h7777, OOB, OOB ? 1 : 2, 0, 0);
    txn(0, 1'b0, 16'h00FF, 16'h0000, ram0[16'h00FF], 1'b0, 2, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of request and RAM address.
REQ-002 Parameter DATA_WIDTH, default 16: width of data words.
REQ-003 Parameter DATA_DEPTH, default 65536: number of valid RAM words.
REQ-004 Parameter WAIT_STATES, default 0: extra RAM latency cycles inserted before capture.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  requester has a transaction.
REQ-008 req_ready  out  1  controller accepts a transaction this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_WIDTH  transaction address.
REQ-011 req_wdata  in  DATA_WIDTH  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  requester consumes the response.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data (write data echo for writes).
REQ-015 rsp_err  out  1  out-of-range access flag.
REQ-016 mem_wr_en  out  1  RAM write enable.
REQ-017 mem_addr  out  ADDR_WIDTH  RAM address.
REQ-018 mem_wr_data  out  DATA_WIDTH  RAM write data.
REQ-019 mem_rd_data  in  DATA_WIDTH  RAM read data; registered, valid one edge after address sampled with mem_wr_en=0.

Function
REQ-020 States: IDLE, ACCESS, WAIT, RESP; all outputs registered.
REQ-021 IDLE: req_ready=1; all other outputs hold; accept when req_valid&&req_ready on an edge.
REQ-022 On accept: latch req_we/req_addr/req_wdata; mem_addr<=req_addr, mem_wr_data<=req_wdata, mem_wr_en<=req_we; go ACCESS.
REQ-023 ACCESS: exactly 1 cycle; req_ready=0; mem_wr_en=latched we; then mem_wr_en<=0 and go WAIT.
REQ-024 WAIT: lasts WAIT_STATES+1 cycles via down-counter; mem_addr held constant throughout.
REQ-025 At last WAIT edge: rsp_rdata<=mem_rd_data for reads, latched wdata for writes; rsp_valid<=1; go RESP.
REQ-026 Latency: rsp_valid high after exactly WAIT_STATES+2 rising edges following the accept edge.
REQ-027 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid&&rsp_ready on an edge; then rsp_valid<=0, go IDLE.
REQ-028 req_ready=0 in every state except IDLE; no pipelining; min issue interval WAIT_STATES+4 cycles with rsp_ready held 1.
REQ-029 req_valid while busy is ignored (not latched); requester holds it until accepted.
REQ-030 mem_wr_en is high for exactly one cycle per write and never for reads.
REQ-031 Addresses pass to mem_addr unmodified (no wrap/translation) unless REQ-038 applies.

Reset
REQ-032 rst asserted: state=IDLE immediately, regardless of clk.
REQ-033 Reset values: req_ready=1 (after deassert), rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counter=0.
REQ-034 Reset during ACCESS aborts the transaction: mem_wr_en drops asynchronously; no response is ever issued for it.
REQ-035 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-036 Macro MEM_CTRL_OOB_CHECK_EN selects out-of-range checking.
REQ-037 Without it: rsp_err constant 0; all addresses access RAM.
REQ-038 With it: accepted address >= DATA_DEPTH skips ACCESS/WAIT, mem_wr_en stays 0, next edge enters RESP with rsp_err=1, rsp_rdata=0 (latency 1 edge).
REQ-039 With it: in-range accesses behave exactly as without it, rsp_err=0.

Verification
REQ-040 WAIT_STATES=0: write 0x1234 to 0x0010, then read 0x0010 -> mem_wr_en one cycle, read rsp_rdata=0x1234, rsp_valid 2 edges after accept.
REQ-041 WAIT_STATES=3: read preloaded 0xBEEF at 0x0005 -> rsp_valid exactly 5 edges after accept, rsp_rdata=0xBEEF.
REQ-042 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid not accepted.
REQ-043 Assert rst during ACCESS of write 0xAAAA to 0x0020 -> mem_wr_en 0 immediately, rsp_valid never asserts, subsequent read returns 0x0020 prior contents.
REQ-044 MEM_CTRL_OOB_CHECK_EN, DATA_DEPTH=256: write to 0x0100 -> rsp_err=1, rsp_rdata=0 after 1 edge, mem_wr_en never 1; without macro same stimulus -> rsp_err=0, normal write.
